// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pkg
// Description : Shared types and constants for the PS/2 mouse position path.
//               The screen limits are also used by the display domain.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

  // Packet assembly states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYTE1  = 2'd1,
    BYTE2  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Bit positions inside PS/2 packet byte 0
  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_M    = 2;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XO   = 6;
  localparam int B0_YO   = 7;

  // Visible area and coordinate width
  localparam int POS_W        = 12;
  localparam int SCREEN_MAX_X = 1023;
  localparam int SCREEN_MAX_Y = 767;

  // Build the 9-bit two's complement delta; an overflowed axis moves by 0
  function automatic logic [8:0] make_delta(input logic sign, input logic [7:0] mag,
                                            input logic ovf);
    return ovf ? 9'd0 : {sign, mag};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_axis_sat.sv
`default_nettype none
// ============================================================================
// Module      : mouse_axis_sat
// Description : Combinational saturating add of an unsigned screen coordinate
//               and a signed delta; result is clamped to 0..MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_axis_sat #(
  parameter int MAX     = 1023,
  parameter int DELTA_W = 9
) (
  input  logic [11:0]        pos,
  input  logic [DELTA_W-1:0] delta,
  output logic [11:0]        result
);

  logic signed [13:0] sum;

  // 14-bit signed sum, then clamp to the legal range
  always_comb begin
    sum = $signed({2'b00, pos}) + $signed({{(14-DELTA_W){delta[DELTA_W-1]}}, delta});
    if (sum < 14'sd0) begin
      result = 12'd0;
    end else if (sum > $signed(14'(MAX))) begin
      result = 12'(MAX);
    end else begin
      result = sum[11:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mouse_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pos_tracker
// Description : Assembles 3-byte PS/2 mouse packets and accumulates the X/Y
//               deltas into saturated absolute screen coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_pos_tracker
  import mouse_pkg::*;
#(
  parameter int MAX_X   = SCREEN_MAX_X,
  parameter int MAX_Y   = SCREEN_MAX_Y,
  parameter int INIT_X  = 512,
  parameter int INIT_Y  = 384,
  parameter int TIMEOUT = 260000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] posX,
  output logic [11:0] posY,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_mid,
  output logic        pos_valid,
  output logic        sync_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [2:0]         hdr_btn_q, hdr_btn_d;    // {M, R, L}
  logic [1:0]         hdr_sign_q, hdr_sign_d;  // {Y sign, X sign}
  logic [1:0]         hdr_ovf_q, hdr_ovf_d;    // {Y ovf, X ovf}
  logic [7:0]         dx_q, dx_d;
  logic [7:0]         dy_q, dy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [11:0]        pos_x_q, pos_x_d;
  logic [11:0]        pos_y_q, pos_y_d;
  logic [2:0]         btn_q, btn_d;
  logic               pos_valid_q, pos_valid_d;
  logic               sync_err_q, sync_err_d;

  logic [8:0]         dx9;
  logic [8:0]         dy9;
  logic [9:0]         dy_neg;
  logic [11:0]        new_x;
  logic [11:0]        new_y;

  // Signed deltas; Y is negated in 10 bits so -256 flips to +256 cleanly
  always_comb begin
    dx9    = make_delta(hdr_sign_q[0], dx_q, hdr_ovf_q[0]);
    dy9    = make_delta(hdr_sign_q[1], dy_q, hdr_ovf_q[1]);
    dy_neg = 10'd0 - {dy9[8], dy9};
  end

  mouse_axis_sat #(.MAX(MAX_X), .DELTA_W(9)) u_sat_x (
    .pos    (pos_x_q),
    .delta  (dx9),
    .result (new_x)
  );

  mouse_axis_sat #(.MAX(MAX_Y), .DELTA_W(10)) u_sat_y (
    .pos    (pos_y_q),
    .delta  (dy_neg),
    .result (new_y)
  );

  // Packet FSM, header/delta latches, inter-byte timeout and output updates
  always_comb begin
    state_d     = state_q;
    hdr_btn_d   = hdr_btn_q;
    hdr_sign_d  = hdr_sign_q;
    hdr_ovf_d   = hdr_ovf_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    cnt_d       = cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    btn_d       = btn_q;
    pos_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    cnt_inc     = cnt_q + 1'b1;

    if (rx_valid) begin
      cnt_d = '0;
    end

    case (state_q)
      IDLE, UPDATE: begin
        if (state_q == UPDATE) begin
          pos_x_d     = new_x;
          pos_y_d     = new_y;
          btn_d       = hdr_btn_q;
          pos_valid_d = 1'b1;
          state_d     = IDLE;
        end
        // A byte arriving during UPDATE is judged as a byte-0 candidate
        if (rx_valid) begin
          if (rx_data[B0_SYNC]) begin
            hdr_btn_d  = {rx_data[B0_M], rx_data[B0_R], rx_data[B0_L]};
            hdr_sign_d = {rx_data[B0_YS], rx_data[B0_XS]};
            hdr_ovf_d  = {rx_data[B0_YO], rx_data[B0_XO]};
            state_d    = BYTE1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      BYTE1, BYTE2: begin
        if (rx_valid) begin
          if (state_q == BYTE1) begin
            dx_d    = rx_data;
            state_d = BYTE2;
          end else begin
            dy_d    = rx_data;
            state_d = UPDATE;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          sync_err_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hdr_btn_q   <= 3'd0;
      hdr_sign_q  <= 2'd0;
      hdr_ovf_q   <= 2'd0;
      dx_q        <= 8'd0;
      dy_q        <= 8'd0;
      cnt_q       <= '0;
      pos_x_q     <= 12'(INIT_X);
      pos_y_q     <= 12'(INIT_Y);
      btn_q       <= 3'd0;
      pos_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_btn_q   <= hdr_btn_d;
      hdr_sign_q  <= hdr_sign_d;
      hdr_ovf_q   <= hdr_ovf_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cnt_q       <= cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      btn_q       <= btn_d;
      pos_valid_q <= pos_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign posX      = pos_x_q;
  assign posY      = pos_y_q;
  assign btn_left  = btn_q[0];
  assign btn_right = btn_q[1];
  assign btn_mid   = btn_q[2];
  assign pos_valid = pos_valid_q;
  assign sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_pos_tracker
// Description : Self-checking bench for mouse_pos_tracker with directed and
//               randomized PS/2 packets against an arithmetic position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_pos_tracker;

  localparam int TB_MAX_X   = 1023;
  localparam int TB_MAX_Y   = 767;
  localparam int TB_INIT_X  = 512;
  localparam int TB_INIT_Y  = 384;
  localparam int TB_TIMEOUT = 40;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] posX;
  logic [11:0] posY;
  logic        btn_left;
  logic        btn_right;
  logic        btn_mid;
  logic        pos_valid;
  logic        sync_err;

  int n_checks;
  int n_fail;

  // Reference state: absolute position and button mask {M,R,L}
  int m_x;
  int m_y;
  int m_btn;

  mouse_pos_tracker #(
    .MAX_X   (TB_MAX_X),
    .MAX_Y   (TB_MAX_Y),
    .INIT_X  (TB_INIT_X),
    .INIT_Y  (TB_INIT_Y),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .posX      (posX),
    .posY      (posY),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_mid   (btn_mid),
    .pos_valid (pos_valid),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // A 9-bit two's complement delta, zero when the overflow flag is set
  function automatic int delta_of(input logic sign, input logic [7:0] mag, input logic ovf);
    if (ovf) return 0;
    return sign ? int'(mag) - 256 : int'(mag);
  endfunction

  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    m_x   = clamp(m_x + delta_of(b0[4], b1, b0[6]), TB_MAX_X);
    m_y   = clamp(m_y - delta_of(b0[5], b2, b0[7]), TB_MAX_Y);
    m_btn = int'(b0[2:0]);
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_x"}, 32'(posX), m_x);
    check_val({tag, "_y"}, 32'(posY), m_y);
    check_val({tag, "_btn"}, 32'({btn_mid, btn_right, btn_left}), m_btn);
  endtask

  // Drive one byte at the current falling edge for one cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    m_x   = TB_INIT_X;
    m_y   = TB_INIT_Y;
    m_btn = 0;
  endtask

  // After the last byte: quiet for one cycle, then a single update pulse
  task automatic check_update(input string tag);
    check_val({tag, "_pv_early"}, 32'(pos_valid), 0);
    @(negedge clk);
    check_val({tag, "_pv"}, 32'(pos_valid), 1);
    check_val({tag, "_se"}, 32'(sync_err), 0);
    check_outputs(tag);
    @(negedge clk);
    check_val({tag, "_pv_late"}, 32'(pos_valid), 0);
  endtask

  task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int g1, input int g2);
    send_byte(b0);
    idle(g1);
    send_byte(b1);
    idle(g2);
    send_byte(b2);
    model_packet(b0, b1, b2);
    check_update(tag);
  endtask

  initial begin
    logic       early;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] junk;

    n_checks = 0;
    n_fail   = 0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    reset_dut();

    // Reset values
    check_outputs("reset");
    check_val("reset_pv", 32'(pos_valid), 0);
    check_val("reset_se", 32'(sync_err), 0);

    // Basic moves
    send_packet("dx16", 8'h08, 8'h10, 8'h00, 0, 0);
    reset_dut();
    send_packet("left_dy32", 8'h09, 8'h00, 8'h20, 1, 2);

    // Saturation at the low X edge and the high Y edge
    reset_dut();
    for (int i = 0; i < 6; i++) send_packet("clamp_lo", 8'h18, 8'h80, 8'h00, 0, 0);
    check_val("clamp_lo_final", 32'(posX), 0);
    for (int i = 0; i < 4; i++) send_packet("clamp_hi", 8'h28, 8'h00, 8'h80, 0, 0);
    check_val("clamp_hi_final", 32'(posY), 767);

    // X overflow flag kills dx only
    reset_dut();
    send_packet("ovf", 8'h48, 8'hFF, 8'h05, 0, 0);
    check_val("ovf_y", 32'(posY), 379);

    // Rejected byte in IDLE
    send_byte(8'h00);
    check_val("rej_se", 32'(sync_err), 1);
    check_val("rej_pv", 32'(pos_valid), 0);
    @(negedge clk);
    check_val("rej_se_late", 32'(sync_err), 0);

    // Inter-byte timeout
    reset_dut();
    send_byte(8'h08);
    early = 1'b0;
    for (int i = 1; i <= TB_TIMEOUT; i++) begin
      @(negedge clk);
      if (i < TB_TIMEOUT) early = early | sync_err;
    end
    check_val("to_early", 32'(early), 0);
    check_val("to_se", 32'(sync_err), 1);
    check_outputs("to_hold");
    @(negedge clk);
    check_val("to_se_late", 32'(sync_err), 0);
    send_packet("to_after", 8'h08, 8'h01, 8'h00, 0, 0);
    check_val("to_after_x", 32'(posX), TB_INIT_X + 1);

    // Reset in the middle of a packet
    send_byte(8'h08);
    send_byte(8'h10);
    reset_dut();
    check_outputs("midrst");
    send_packet("midrst_next", 8'h08, 8'h05, 8'h00, 0, 0);

    // Rejected byte arriving in the UPDATE cycle
    send_byte(8'h08);
    send_byte(8'h02);
    send_byte(8'h00);
    model_packet(8'h08, 8'h02, 8'h00);
    check_val("ovl_pv_early", 32'(pos_valid), 0);
    send_byte(8'h00);
    check_val("ovl_pv", 32'(pos_valid), 1);
    check_val("ovl_se", 32'(sync_err), 1);
    check_outputs("ovl");
    @(negedge clk);
    check_val("ovl_pv_late", 32'(pos_valid), 0);
    check_val("ovl_se_late", 32'(sync_err), 0);

    // Valid byte 0 arriving in the UPDATE cycle is not lost
    send_byte(8'h08);
    send_byte(8'h03);
    send_byte(8'h00);
    model_packet(8'h08, 8'h03, 8'h00);
    send_byte(8'h0A);
    check_val("ovl2_pv", 32'(pos_valid), 1);
    check_outputs("ovl2");
    send_byte(8'h01);
    send_byte(8'hF0);
    model_packet(8'h0A, 8'h01, 8'hF0);
    check_update("ovl2_next");

    // Randomized packets with gaps and junk bytes
    reset_dut();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom) & 8'hF7;
        send_byte(junk);
        check_val("rnd_junk_se", 32'(sync_err), 1);
      end
      b0 = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send_packet("rnd", b0, b1, b2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
